// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin arbiter that serialises captured 32-bit words MSB-first
// onto a byte transmitter. Define TX_HEADER_EN to prefix each frame with 8'hA0 | grant.
module serial_tx_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic [7:0]  tx_data,
  output logic        tx_new_data,
  input  logic        tx_busy,
  output logic        active,
  output logic        grant
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_ACC  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

`ifdef TX_HEADER_EN
  localparam logic [2:0] FRAME_LEN = 3'd5;
`else
  localparam logic [2:0] FRAME_LEN = 3'd4;
`endif

  logic [1:0]  state;
  logic [31:0] shreg;
  logic [2:0]  byte_cnt;
  logic        last;
  logic        sel;
  logic [7:0]  cur_byte;
  logic        shift_en;

  // Round-robin: on a tie serve the requester that was not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sel = req1;
    if (req0 && req1) sel = ~last;
  end

  always_comb begin
    cur_byte = shreg[31:24];
    shift_en = 1'b1;
`ifdef TX_HEADER_EN
    if (byte_cnt == 3'd0) begin
      cur_byte = 8'hA0 | {7'd0, grant};
      shift_en = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      byte_cnt    <= '0;
      last        <= 1'b1;
      grant       <= 1'b0;
      active      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      tx_data     <= 8'h00;
      tx_new_data <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; pulses default low each cycle.
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      tx_new_data <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            shreg    <= sel ? data1 : data0;
            ack0     <= ~sel;
            ack1     <= sel;
            grant    <= sel;
            last     <= sel;
            active   <= 1'b1;
            byte_cnt <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!tx_busy) begin
            tx_data     <= cur_byte;
            tx_new_data <= 1'b1;
            byte_cnt    <= byte_cnt + 3'd1;
            if (shift_en) shreg <= {shreg[23:0], 8'h00};
            state       <= WAIT_ACC;
          end
        end
        WAIT_ACC: begin
          // Transmitter raises busy one cycle after the strobe; never re-strobe here.
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (byte_cnt >= FRAME_LEN) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 SHALL have no parameters; the word width is fixed at 32 bits and the byte width at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 req0  input  1  requester 0 send request, level; held high until ack0.
REQ-005 data0  input  32  requester 0 word; stable while req0=1 and ack0=0.
REQ-006 ack0  output  1  one-cycle pulse; data0 has been captured.
REQ-007 req1  input  1  requester 1 send request; same rules as req0.
REQ-008 data1  input  32  requester 1 word.
REQ-009 ack1  output  1  one-cycle pulse; data1 has been captured.
REQ-010 tx_data  output  8  byte to the serial transmitter.
REQ-011 tx_new_data  output  1  one-cycle strobe; tx_data is valid.
REQ-012 tx_busy  input  1  transmitter busy; registered on the transmitter side and rises one cycle after the strobe.
REQ-013 active  output  1  high from the capture cycle until the last byte completes.
REQ-014 grant  output  1  index of the requester being served; valid while active=1.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_ACC, WAIT_DONE.
REQ-016 In IDLE with any req high, the arbiter SHALL capture the selected word into an internal shift register, pulse the matching ack for one cycle, set grant, set active, and go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: if both reqs are high, grant the requester not served last; if only one is high, grant that one.
REQ-018 A req asserted while the arbiter is not in IDLE SHALL wait. Exactly one ack SHALL pulse per served word.
REQ-019 ISSUE: when tx_busy=0, the arbiter SHALL drive tx_data to the current byte, pulse tx_new_data for exactly one cycle, and go to WAIT_ACC. While tx_busy=1, it SHALL stay in ISSUE with tx_new_data=0.
REQ-020 WAIT_ACC SHALL hold until tx_busy=1, then go to WAIT_DONE. The strobe SHALL never be reissued for the same byte.
REQ-021 WAIT_DONE SHALL hold until tx_busy=0. It SHALL then go to ISSUE if bytes remain. Otherwise it SHALL clear active and go to IDLE.
REQ-022 Payload byte order SHALL be MSB first: data[31:24], [23:16], [15:8], [7:0].
REQ-023 A 3-bit byte counter SHALL count bytes sent. The word is complete when the counter reaches the frame length of 4, or 5 with the header. The counter SHALL NOT wrap within a frame.
REQ-024 Minimum gap from the end of one frame to the next capture SHALL be 1 cycle (the IDLE cycle).
REQ-025 tx_data SHALL hold its last value when tx_new_data=0.

Reset
REQ-026 When rst_n=0, the block SHALL immediately set state=IDLE, ack0=0, ack1=0, tx_new_data=0, tx_data=8'h00, active=0, grant=0, byte counter=0, and last-served pointer=1 so that requester 0 wins the first tie.
REQ-027 A reset mid-frame SHALL abandon the frame with no further strobes. The aborted word SHALL NOT be re-sent and SHALL NOT be re-acked.
REQ-028 After rst_n deasserts, the first capture SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-029 Macro TX_HEADER_EN: when defined, each frame SHALL be prefixed by header byte 8'hA0 | grant, giving 5 bytes per frame. When undefined, no header is sent and frames are 4 bytes. All other behaviour SHALL be identical in both builds.

Verification
REQ-030 Single request, header off: req0 with data0=32'h12345678 -> ack0 pulses once; tx_data sequence 12,34,56,78; exactly 4 strobes; then active=0.
REQ-031 Tie: req0 and req1 rise together (data 32'hAAAAAAAA, 32'h55555555) -> req0 is served first, then req1; ack0 precedes ack1; 8 bytes in order AA×4, 55×4.
REQ-032 Round-robin: req0 held continuously for back-to-back words with req1 raised during frame 1 -> frame 2 has grant=1.
REQ-033 Flow control: transmitter model holds tx_busy=1 for 500 cycles per byte -> no strobe while busy; one strobe per byte; gap of 1 or more cycles between each busy fall and the next strobe.
REQ-034 Header on (TX_HEADER_EN): req1 with data1=32'hDEADBEEF -> bytes A1,DE,AD,BE,EF.
REQ-035 Reset during byte 2 -> outputs reach reset values asynchronously; no further strobes; a new req0 after reset starts a fresh frame from byte 0.
